packet_bus_master: RTL and testbench

Bus-side replay engine for the receive path of the NIC. Accepts one fully reassembled packet from the network side and executes it on the bus as a master transaction: single or incrementing burst, write or read. Handles beat-by-beat ACK/ERR handshaking and returns read data plus a completion pulse. It is the counterpart of the block that collects bus bursts and packs them into packets.

---
 rtl/packet_bus_master_pkg.sv | 50 +++++
 rtl/packet_bus_master_if.sv | 26 ++
 rtl/packet_bus_master_pkt_to_msg.sv | 24 ++
 rtl/packet_bus_master.sv | 161 ++++++++++++++++
 tb/tb_packet_bus_master.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/packet_bus_master_pkg.sv
// Shared parameters, packet field layout and FSM state type for the bus-side
// packet replay engine. The packetizer uses the same offsets, so both directions agree.
package packet_bus_master_pkg;

  localparam int BUS_ADDRESS_WIDTH   = 32;
  localparam int BUS_DATA_WIDTH      = 32;
  localparam int BUS_SEL_WIDTH       = 4;
  localparam int MAX_BURST_LENGHT    = 8;
  localparam int N_BITS_BURST_LENGHT = 5;
  localparam int N_BITS_VNET_ID      = 2;
  localparam int FLIT_WIDTH          = 32;
  localparam int MAX_PACKET_LENGHT   = 11;

  localparam int PKT_WIDTH      = MAX_PACKET_LENGHT * FLIT_WIDTH;
  localparam int BEAT_IDX_WIDTH = $clog2(MAX_BURST_LENGHT);

  // Packet layout, LSB first: address, WE, beat count, data words, sel fields.
  localparam int PKT_ADDR_OFS   = 0;
  localparam int PKT_WE_OFS     = PKT_ADDR_OFS + BUS_ADDRESS_WIDTH;
  localparam int PKT_CNT_OFS    = PKT_WE_OFS + 1;
  localparam int PKT_DATA_OFS   = PKT_CNT_OFS + N_BITS_BURST_LENGHT;
  localparam int PKT_SEL_OFS    = PKT_DATA_OFS + MAX_BURST_LENGHT * BUS_DATA_WIDTH;
  localparam int PKT_USED_WIDTH = PKT_SEL_OFS + MAX_BURST_LENGHT * BUS_SEL_WIDTH;

  localparam logic [BUS_ADDRESS_WIDTH-1:0] BEAT_BYTES = BUS_ADDRESS_WIDTH'(BUS_DATA_WIDTH / 8);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef logic [MAX_BURST_LENGHT-1:0][BUS_DATA_WIDTH-1:0] data_words_t;
  typedef logic [MAX_BURST_LENGHT-1:0][BUS_SEL_WIDTH-1:0]  sel_words_t;

  // A zero count still moves one beat; oversized counts saturate at the burst limit.
  function automatic logic [N_BITS_BURST_LENGHT-1:0] clamp_count(
      input logic [N_BITS_BURST_LENGHT-1:0] raw);
    logic [N_BITS_BURST_LENGHT-1:0] res;
    if (raw == N_BITS_BURST_LENGHT'(0)) begin
      res = N_BITS_BURST_LENGHT'(1);
    end else if (raw > N_BITS_BURST_LENGHT'(MAX_BURST_LENGHT)) begin
      res = N_BITS_BURST_LENGHT'(MAX_BURST_LENGHT);
    end else begin
      res = raw;
    end
    return res;
  endfunction

endpackage

// File: rtl/packet_bus_master_if.sv
// Bus-side signals of the replay engine; the master drives the request,
// the slave returns read data and the per-beat ACK/ERR.
interface packet_bus_master_if;
  import packet_bus_master_pkg::*;

  logic [BUS_ADDRESS_WIDTH-1:0] ADR_O;
  logic [BUS_DATA_WIDTH-1:0]    DAT_O;
  logic [BUS_SEL_WIDTH-1:0]     SEL_O;
  logic                         WE_O;
  logic                         CYC_O;
  logic                         STB_O;
  logic [BUS_DATA_WIDTH-1:0]    DAT_I;
  logic                         ACK_I;
  logic                         ERR_I;

  modport master (
    output ADR_O, DAT_O, SEL_O, WE_O, CYC_O, STB_O,
    input  DAT_I, ACK_I, ERR_I
  );

  modport slave (
    input  ADR_O, DAT_O, SEL_O, WE_O, CYC_O, STB_O,
    output DAT_I, ACK_I, ERR_I
  );

endinterface

// File: rtl/packet_bus_master_pkt_to_msg.sv
// Combinational unpacker: splits a reassembled packet into address, WE,
// raw beat count and the flat data/sel word arrays.
module packet_bus_master_pkt_to_msg
  import packet_bus_master_pkg::*;
(
  input  logic [PKT_WIDTH-1:0]                        pkt,
  output logic [BUS_ADDRESS_WIDTH-1:0]                addr,
  output logic                                        we,
  output logic [N_BITS_BURST_LENGHT-1:0]              count,
  output logic [MAX_BURST_LENGHT*BUS_DATA_WIDTH-1:0]  data,
  output logic [MAX_BURST_LENGHT*BUS_SEL_WIDTH-1:0]   sel
);

  // Flit padding above the last sel field carries nothing.
  logic [PKT_WIDTH-PKT_USED_WIDTH-1:0] unused_tail_s;

  assign addr          = pkt[PKT_ADDR_OFS +: BUS_ADDRESS_WIDTH];
  assign we            = pkt[PKT_WE_OFS];
  assign count         = pkt[PKT_CNT_OFS +: N_BITS_BURST_LENGHT];
  assign data          = pkt[PKT_DATA_OFS +: MAX_BURST_LENGHT * BUS_DATA_WIDTH];
  assign sel           = pkt[PKT_SEL_OFS +: MAX_BURST_LENGHT * BUS_SEL_WIDTH];
  assign unused_tail_s = pkt[PKT_WIDTH-1:PKT_USED_WIDTH];

endmodule

// File: rtl/packet_bus_master.sv
// Replays one received packet as a bus master transaction (single or
// incrementing burst, read or write) and reports completion with read data.
module packet_bus_master
  import packet_bus_master_pkg::*;
(
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [PKT_WIDTH-1:0]                       pkt_i,
  input  logic [N_BITS_VNET_ID-1:0]                  vnet_id_i,
  input  logic                                       is_valid_i,
  output logic                                       ready_o,
  packet_bus_master_if.master                        bus,
  output logic [MAX_BURST_LENGHT*BUS_DATA_WIDTH-1:0] rsp_data_o,
  output logic [N_BITS_VNET_ID-1:0]                  vnet_id_o,
  output logic                                       done_o,
  output logic                                       err_o
);

  state_e                                     state_r, state_s;
  logic [BUS_ADDRESS_WIDTH-1:0]               msg_addr_s;
  logic                                       msg_we_s;
  logic [N_BITS_BURST_LENGHT-1:0]             msg_count_s;
  logic [MAX_BURST_LENGHT*BUS_DATA_WIDTH-1:0] msg_data_s;
  logic [MAX_BURST_LENGHT*BUS_SEL_WIDTH-1:0]  msg_sel_s;

  data_words_t                    data_r, rsp_buf_r, rsp_out_r, rsp_next_s;
  sel_words_t                     sel_r;
  logic [N_BITS_BURST_LENGHT-1:0] count_r, k_r;
  logic [BEAT_IDX_WIDTH-1:0]      k_idx_s, k_idx_next_s;
  logic [N_BITS_VNET_ID-1:0]      vnet_r, vnet_out_r;
  logic [BUS_ADDRESS_WIDTH-1:0]   adr_r;
  logic [BUS_DATA_WIDTH-1:0]      dat_r;
  logic [BUS_SEL_WIDTH-1:0]       sel_out_r;
  logic                           we_r, cyc_r, ready_r, done_r, err_r;
  logic                           accept_s, last_s, ack_beat_s, err_beat_s;

  packet_bus_master_pkt_to_msg u_pkt_to_msg (
    .pkt   (pkt_i),
    .addr  (msg_addr_s),
    .we    (msg_we_s),
    .count (msg_count_s),
    .data  (msg_data_s),
    .sel   (msg_sel_s)
  );

  assign accept_s     = is_valid_i && ready_r;
  assign k_idx_s      = k_r[BEAT_IDX_WIDTH-1:0];
  assign k_idx_next_s = k_idx_s + BEAT_IDX_WIDTH'(1);
  assign last_s       = (k_r == (count_r - N_BITS_BURST_LENGHT'(1)));
  // ERR wins over a simultaneous ACK: the beat is neither captured nor advanced.
  assign err_beat_s   = (state_r == ST_XFER) && bus.ERR_I;
  assign ack_beat_s   = (state_r == ST_XFER) && bus.ACK_I && !bus.ERR_I;

  // Read capture view: the current beat's word replaced by DAT_I on a read ACK.
  always_comb begin
    rsp_next_s = rsp_buf_r;
    if (ack_beat_s && !we_r) begin
      rsp_next_s[k_idx_s] = bus.DAT_I;
    end else begin
      rsp_next_s = rsp_buf_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_XFER;
        else          state_s = ST_IDLE;
      end
      ST_XFER: begin
        if (err_beat_s || (ack_beat_s && last_s)) state_s = ST_DONE;
        else                                      state_s = ST_XFER;
      end
      ST_DONE: begin
        if (accept_s) state_s = ST_XFER;
        else          state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_s;
  end

  // Packet latch, beat sequencing, registered bus outputs and response capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adr_r      <= '0;
      dat_r      <= '0;
      sel_out_r  <= '0;
      we_r       <= 1'b0;
      cyc_r      <= 1'b0;
      ready_r    <= 1'b1;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      k_r        <= '0;
      count_r    <= '0;
      vnet_r     <= '0;
      vnet_out_r <= '0;
      data_r     <= '0;
      sel_r      <= '0;
      rsp_buf_r  <= '0;
      rsp_out_r  <= '0;
    end else begin
      ready_r <= (state_s != ST_XFER);
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      if (accept_s) begin
        adr_r     <= msg_addr_s;
        dat_r     <= msg_data_s[BUS_DATA_WIDTH-1:0];
        sel_out_r <= msg_sel_s[BUS_SEL_WIDTH-1:0];
        we_r      <= msg_we_s;
        cyc_r     <= 1'b1;
        k_r       <= '0;
        count_r   <= clamp_count(msg_count_s);
        vnet_r    <= vnet_id_i;
        data_r    <= msg_data_s;
        sel_r     <= msg_sel_s;
        // Words this packet does not capture must keep the last published values.
        rsp_buf_r <= rsp_out_r;
      end else if (err_beat_s) begin
        cyc_r      <= 1'b0;
        done_r     <= 1'b1;
        err_r      <= 1'b1;
        vnet_out_r <= vnet_r;
        rsp_out_r  <= rsp_buf_r;
      end else if (ack_beat_s) begin
        rsp_buf_r <= rsp_next_s;
        if (last_s) begin
          cyc_r      <= 1'b0;
          done_r     <= 1'b1;
          vnet_out_r <= vnet_r;
          rsp_out_r  <= rsp_next_s;
        end else begin
          k_r       <= k_r + N_BITS_BURST_LENGHT'(1);
          adr_r     <= adr_r + BEAT_BYTES;
          dat_r     <= data_r[k_idx_next_s];
          sel_out_r <= sel_r[k_idx_next_s];
        end
      end
    end
  end

  assign bus.ADR_O  = adr_r;
  assign bus.DAT_O  = dat_r;
  assign bus.SEL_O  = sel_out_r;
  assign bus.WE_O   = we_r;
  assign bus.CYC_O  = cyc_r;
  assign bus.STB_O  = cyc_r;
  assign ready_o    = ready_r;
  assign rsp_data_o = rsp_out_r;
  assign vnet_id_o  = vnet_out_r;
  assign done_o     = done_r;
  assign err_o      = err_r;

endmodule

// File: tb/tb_packet_bus_master.sv
// Directed bench: each packet pushes its expected bus beats and completion
// onto scoreboard queues; a responding slave loop pops and compares them.
module tb_packet_bus_master;
  import packet_bus_master_pkg::*;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    int          wait_n;
    bit          err;
    logic [31:0] rd;
  } beat_t;

  typedef struct {
    logic [1:0]   vnet;
    logic         err;
    logic [255:0] rsp;
    int           cycles;
  } done_t;

  logic                                       clk;
  logic                                       rst;
  logic [PKT_WIDTH-1:0]                       pkt_i;
  logic [N_BITS_VNET_ID-1:0]                  vnet_id_i;
  logic                                       is_valid_i;
  logic                                       ready_o;
  logic [MAX_BURST_LENGHT*BUS_DATA_WIDTH-1:0] rsp_data_o;
  logic [N_BITS_VNET_ID-1:0]                  vnet_id_o;
  logic                                       done_o;
  logic                                       err_o;

  packet_bus_master_if bus_if ();

  packet_bus_master dut (
    .clk        (clk),
    .rst        (rst),
    .pkt_i      (pkt_i),
    .vnet_id_i  (vnet_id_i),
    .is_valid_i (is_valid_i),
    .ready_o    (ready_o),
    .bus        (bus_if),
    .rsp_data_o (rsp_data_o),
    .vnet_id_o  (vnet_id_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t        exp_q[$];
  done_t        done_q[$];
  logic [255:0] rsp_model;
  int           n_tests;
  int           n_fail;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Build a packet, queue its expected beats/completion and raise is_valid_i.
  task automatic launch(input logic [31:0] addr, input logic we, input logic [4:0] cnt,
                        input logic [1:0] vnet, input logic [31:0] d0, input logic [3:0] s0,
                        input int wait_n, input int err_at, input logic [31:0] rd_base);
    int                   n;
    int                   cyc;
    beat_t                b;
    done_t                d;
    logic [31:0]          dw [8];
    logic [3:0]           sw [8];
    logic [PKT_WIDTH-1:0] p;
    n = (cnt == 5'd0) ? 1 : ((cnt > 5'd8) ? 8 : int'(cnt));
    p = '0;
    p[31:0]  = addr;
    p[32]    = we;
    p[37:33] = cnt;
    for (int i = 0; i < 8; i++) begin
      dw[i] = (i == 0) ? d0 : $urandom;
      sw[i] = (i == 0) ? s0 : 4'($urandom_range(1, 15));
      p[38 + 32*i +: 32] = dw[i];
      p[294 + 4*i +: 4]  = sw[i];
    end
    cyc   = 0;
    d.err = 1'b0;
    for (int i = 0; i < n; i++) begin
      b.adr    = addr + 32'(4 * i);
      b.dat    = dw[i];
      b.sel    = sw[i];
      b.we     = we;
      b.wait_n = wait_n;
      b.err    = (i == err_at);
      b.rd     = rd_base + 32'(i) * 32'h11;
      cyc += wait_n + 1;
      exp_q.push_back(b);
      if (b.err) begin
        d.err = 1'b1;
        break;
      end
      if (!we) rsp_model[32*i +: 32] = b.rd;
    end
    d.vnet   = vnet;
    d.rsp    = rsp_model;
    d.cycles = cyc;
    done_q.push_back(d);
    pkt_i      = p;
    vnet_id_i  = vnet;
    is_valid_i = 1'b1;
  endtask

  task automatic accept_step();
    @(negedge clk);
    is_valid_i = 1'b0;
    chk("cyc_start", bus_if.CYC_O, 1'b1);
  endtask

  // Slave model: checks every strobed cycle, acks after wait_n cycles, checks completions.
  task automatic run_bus(input int n_done, input int stop_after);
    int    done_seen = 0;
    int    acked = 0;
    int    wcnt = 0;
    int    cyc_cnt = 0;
    int    budget = 0;
    bit    clr = 1'b0;
    bit    expect_cyc = 1'b0;
    beat_t b;
    done_t d;
    while (done_seen < n_done) begin
      bus_if.ACK_I = 1'b0;
      bus_if.ERR_I = 1'b0;
      if (clr) begin
        is_valid_i = 1'b0;
        clr = 1'b0;
      end
      if (expect_cyc) begin
        chk("cyc_after_b2b", bus_if.CYC_O, 1'b1);
        expect_cyc = 1'b0;
      end
      if (done_o) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", done_o, 1'b0);
        end else begin
          d = done_q.pop_front();
          chk("done_err", err_o, d.err);
          chk("done_vnet", vnet_id_o, d.vnet);
          chk("done_rsp", rsp_data_o, d.rsp);
          chk("done_cyc_low", {bus_if.CYC_O, bus_if.STB_O}, 2'b00);
          chk("done_ready", ready_o, 1'b1);
          chk("done_latency", cyc_cnt, d.cycles);
        end
        cyc_cnt = 0;
        done_seen++;
        if (is_valid_i) begin
          clr = 1'b1;
          expect_cyc = 1'b1;
        end
      end else if (bus_if.CYC_O) begin
        cyc_cnt++;
        chk("stb", bus_if.STB_O, 1'b1);
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", bus_if.CYC_O, 1'b0);
        end else begin
          b = exp_q[0];
          chk("adr", bus_if.ADR_O, b.adr);
          chk("dat", bus_if.DAT_O, b.dat);
          chk("sel", bus_if.SEL_O, b.sel);
          chk("we", bus_if.WE_O, b.we);
          if (acked == stop_after) return;
          if (wcnt < b.wait_n) begin
            wcnt++;
          end else begin
            wcnt = 0;
            b = exp_q.pop_front();
            acked++;
            bus_if.DAT_I = b.rd;
            bus_if.ACK_I = 1'b1;
            bus_if.ERR_I = b.err;
          end
        end
      end
      if (done_seen < n_done) begin
        budget++;
        if (budget > 300) begin
          chk("bus_timeout", 1'b0, 1'b1);
          return;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic idle(input int n, input bit spurious);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus_if.ACK_I = spurious;
      bus_if.ERR_I = spurious;
      chk("idle_done", done_o, 1'b0);
      chk("idle_cyc", bus_if.CYC_O, 1'b0);
      chk("idle_ready", ready_o, 1'b1);
    end
    bus_if.ACK_I = 1'b0;
    bus_if.ERR_I = 1'b0;
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rsp_model    = '0;
    is_valid_i   = 1'b0;
    pkt_i        = '0;
    vnet_id_i    = '0;
    bus_if.ACK_I = 1'b0;
    bus_if.ERR_I = 1'b0;
    bus_if.DAT_I = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_cyc_stb", {bus_if.CYC_O, bus_if.STB_O}, 2'b00);
    chk("rst_done_err", {done_o, err_o}, 2'b00);
    chk("rst_rsp", rsp_data_o, 256'd0);
    chk("rst_vnet", vnet_id_o, 2'd0);
    chk("rst_bus", {bus_if.ADR_O, bus_if.DAT_O, bus_if.SEL_O, bus_if.WE_O}, 69'd0);
    rst = 1'b1;
    idle(2, 1'b1);

    // Single zero-wait write
    chk("ready_single", ready_o, 1'b1);
    launch(32'h0000_1000, 1'b1, 5'd1, 2'd1, 32'hDEAD_BEEF, 4'hF, 0, -1, $urandom);
    accept_step();
    run_bus(1, -1);
    idle(2, 1'b1);

    // 4-beat write, two wait states per beat
    launch(32'h0000_2000, 1'b1, 5'd4, 2'd2, $urandom, 4'h3, 2, -1, 32'd0);
    accept_step();
    run_bus(1, -1);
    idle(1, 1'b0);

    // 3-beat read
    launch(32'h0000_3000, 1'b0, 5'd3, 2'd3, $urandom, 4'hF, 0, -1, 32'h11);
    accept_step();
    run_bus(1, -1);
    idle(1, 1'b0);
    chk("rsp_read3", rsp_data_o[95:0], 96'h00000033_00000022_00000011);

    // ERR (with ACK) on beat 1 of a 4-beat write
    launch(32'h0000_4000, 1'b1, 5'd4, 2'd0, $urandom, 4'hC, 0, 1, 32'd0);
    accept_step();
    run_bus(1, -1);
    idle(2, 1'b0);

    // Count 0 executes one beat, count 15 executes eight
    launch(32'h0000_5000, 1'b0, 5'd0, 2'd1, $urandom, 4'h1, 1, -1, 32'hA000_0000);
    accept_step();
    run_bus(1, -1);
    idle(1, 1'b0);
    launch(32'h0000_6000, 1'b0, 5'd15, 2'd2, $urandom, 4'h7, 0, -1, 32'h0101_0101);
    accept_step();
    run_bus(1, -1);
    idle(1, 1'b0);

    // Back-to-back with is_valid_i held; second packet wraps the address space
    launch(32'h0000_7000, 1'b1, 5'd2, 2'd1, $urandom, 4'h9, 0, -1, 32'd0);
    accept_step();
    launch(32'hFFFF_FFFC, 1'b0, 5'd2, 2'd2, $urandom, 4'h6, 0, -1, 32'h5A5A_0000);
    run_bus(2, -1);
    idle(2, 1'b0);

    // Reset during beat 2 of 8
    launch(32'h0000_8000, 1'b1, 5'd8, 2'd3, $urandom, 4'hF, 0, -1, 32'd0);
    accept_step();
    run_bus(1, 2);
    rst = 1'b0;
    #1;
    chk("rst_mid_cyc_stb", {bus_if.CYC_O, bus_if.STB_O}, 2'b00);
    chk("rst_mid_ready", ready_o, 1'b1);
    chk("rst_mid_done", done_o, 1'b0);
    exp_q.delete();
    done_q.delete();
    rsp_model = '0;
    @(negedge clk);
    chk("rst_mid_no_done", done_o, 1'b0);
    rst = 1'b1;
    idle(1, 1'b0);
    launch(32'h0000_9000, 1'b0, 5'd2, 2'd1, $urandom, 4'h2, 1, -1, 32'h1234_0000);
    accept_step();
    run_bus(1, -1);
    idle(1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
